// File: rtl/hdmi_rx_timing.sv
// hdmi_rx_timing: recovers line/frame timing from the one-bit-per-lane
// TMDS stream, locks onto hsync, regenerates de/hsync/vsync and expands
// the lane bits back to 8-bit RGB. Two-stage pipeline: A samples, B outputs.
module hdmi_rx_timing #(
  parameter int H_SYNC     = 44,
  parameter int H_BACK     = 148,
  parameter int H_ACTIVE   = 1920,
  parameter int H_TOTAL    = 2200,
  parameter int V_SYNC     = 5,
  parameter int V_BACK     = 36,
  parameter int V_ACTIVE   = 1080,
  parameter int LOCK_LINES = 4
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic [2:0]  tmds_d_p,
  input  logic [2:0]  tmds_d_n,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        locked,
  output logic        diff_err,
  output logic [15:0] line_err_cnt
);

  localparam int HW = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_LO = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_DE_HI = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0]   V_DE_LO = 11'(V_SYNC + V_BACK);
  localparam logic [10:0]   V_DE_HI = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0]   V_MAX   = 11'd2047;
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_LINES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  // Stage A registers
  logic [2:0] s_q;
  logic       s1_prev_q;
  logic       s2_prev_q;
  logic       diff_err_q;

  // Timing state
  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [10:0]     v_cnt_q, v_cnt_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic [15:0]     line_err_cnt_q, line_err_cnt_d;

  // Stage B output registers
  logic            de_q, de_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic [7:0]      red_q, red_d;
  logic [7:0]      green_q, green_d;
  logic [7:0]      blue_q, blue_d;
  logic            locked_q, locked_d;

  logic            de_int;
  logic            hs_edge;
  logic            vs_edge;
  logic            wrap_pt;
  logic            err_inc;
  logic [HW-1:0]   h_cur;
  logic [10:0]     v_cur;

  // Stage A: sample the true lanes, keep previous sync bits, flag p == n on any lane
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= 3'b000;
      s1_prev_q  <= 1'b0;
      s2_prev_q  <= 1'b0;
      diff_err_q <= 1'b0;
    end else begin
      s_q        <= tmds_d_p;
      s1_prev_q  <= s_q[1];
      s2_prev_q  <= s_q[2];
      diff_err_q <= |(tmds_d_p ~^ tmds_d_n);
    end
  end

  // Line classification, lock FSM next state, counters and output next values
  always_comb begin
    de_int = (state_q == LOCKED) &&
             (h_cnt_q >= H_DE_LO) && (h_cnt_q < H_DE_HI) &&
             (v_cnt_q >= V_DE_LO) && (v_cnt_q < V_DE_HI);
    hs_edge = s_q[1] & ~s1_prev_q & ~de_int;
    vs_edge = s_q[2] & ~s2_prev_q & ~de_int;
    // h_cnt_q == 0 marks the sample where an hsync edge must appear
    wrap_pt = (h_cnt_q == '0);

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_inc    = 1'b0;

    case (state_q)
      SEARCH: begin
        if (hs_edge) begin
          state_d    = VERIFY;
          good_cnt_d = '0;
        end
      end
      VERIFY: begin
        if (hs_edge && wrap_pt) begin
          good_cnt_d = good_cnt_q + 1'b1;
          if (good_cnt_d == GOOD_LOCK) state_d = LOCKED;
        end else if (hs_edge) begin
          good_cnt_d = '0;
        end else if (wrap_pt) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (hs_edge && !wrap_pt) begin
          err_inc    = 1'b1;
          state_d    = VERIFY;
          good_cnt_d = '0;
        end else if (!hs_edge && wrap_pt) begin
          err_inc = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase

    // Any qualified edge places the current sample at pixel 0 of a line
    h_cur   = hs_edge ? '0 : h_cnt_q;
    h_cnt_d = (h_cur == H_LAST) ? '0 : h_cur + 1'b1;

    v_cur   = vs_edge ? '0 : v_cnt_q;
    v_cnt_d = ((h_cur == H_LAST) && (v_cur != V_MAX)) ? v_cur + 1'b1 : v_cur;

    line_err_cnt_d = (err_inc && (line_err_cnt_q != 16'hFFFF)) ?
                     line_err_cnt_q + 1'b1 : line_err_cnt_q;

    de_d     = de_int;
    locked_d = (state_d == LOCKED);
    if (de_int) begin
      red_d   = {8{s_q[0]}};
      green_d = {8{s_q[1]}};
      blue_d  = {8{s_q[2]}};
      hsync_d = hsync_q;
      vsync_d = vsync_q;
    end else begin
      red_d   = 8'h00;
      green_d = 8'h00;
      blue_d  = 8'h00;
      hsync_d = s_q[1];
      vsync_d = s_q[2];
    end
  end

  // Stage B: FSM state, counters and all registered outputs
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SEARCH;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      good_cnt_q     <= '0;
      line_err_cnt_q <= '0;
      de_q           <= 1'b0;
      hsync_q        <= 1'b0;
      vsync_q        <= 1'b0;
      red_q          <= 8'h00;
      green_q        <= 8'h00;
      blue_q         <= 8'h00;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      good_cnt_q     <= good_cnt_d;
      line_err_cnt_q <= line_err_cnt_d;
      de_q           <= de_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      red_q          <= red_d;
      green_q        <= green_d;
      blue_q         <= blue_d;
      locked_q       <= locked_d;
    end
  end

  assign de           = de_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign locked       = locked_q;
  assign diff_err     = diff_err_q;
  assign line_err_cnt = line_err_cnt_q;

endmodule

// File: tb/tb_hdmi_rx_timing.sv
// Testbench for hdmi_rx_timing: drives a small-format TMDS-like stream with
// random active data and checks every output against a timeline model.
module tb_hdmi_rx_timing;

  localparam int H_SYNC     = 4;
  localparam int H_BACK     = 4;
  localparam int H_ACTIVE   = 16;
  localparam int H_TOTAL    = 32;
  localparam int V_SYNC     = 1;
  localparam int V_BACK     = 1;
  localparam int V_ACTIVE   = 4;
  localparam int V_TOTAL    = 8;
  localparam int LOCK_LINES = 4;

  localparam int HA_LO = H_SYNC + H_BACK;
  localparam int HA_HI = H_SYNC + H_BACK + H_ACTIVE;
  localparam int VA_LO = V_SYNC + V_BACK;
  localparam int VA_HI = V_SYNC + V_BACK + V_ACTIVE;

  logic        pix_clk = 1'b0;
  logic        rst_n   = 1'b1;
  logic [2:0]  tmds_d_p = 3'b000;
  logic [2:0]  tmds_d_n = 3'b111;
  logic        de, hsync, vsync, locked, diff_err;
  logic [7:0]  red, green, blue;
  logic [15:0] line_err_cnt;

  hdmi_rx_timing #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .LOCK_LINES(LOCK_LINES)
  ) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .tmds_d_p(tmds_d_p), .tmds_d_n(tmds_d_n),
    .de(de), .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .locked(locked), .diff_err(diff_err), .line_err_cnt(line_err_cnt)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct packed {
    logic        de, hs, vs, lk;
    logic [7:0]  r, g, b;
    logic [15:0] err;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;
  int diff_seen = 0;
  int diff_pending = 0;
  exp_t e_prev;

  // Reference model: line phase is the distance in samples from the last
  // accepted hsync edge; mode 0 = searching, 1 = verifying, 2 = locked.
  int m_t = 0, m_anchor = 0, m_mode = 0, m_good = 0, m_err = 0, m_line = 0;
  bit m_prev1 = 0, m_prev2 = 0, m_hs = 0, m_vs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic bit model_de();
    int pos;
    pos = (m_t - m_anchor) % H_TOTAL;
    return (m_mode == 2) && (pos >= HA_LO) && (pos < HA_HI) &&
           (m_line >= VA_LO) && (m_line < VA_HI);
  endfunction

  task automatic model_step(input logic [2:0] p, output exp_t e);
    int pos;
    bit d, hs_e, vs_e;
    pos  = (m_t - m_anchor) % H_TOTAL;
    d    = model_de();
    hs_e = p[1] && !m_prev1 && !d;
    vs_e = p[2] && !m_prev2 && !d;
    if (vs_e) m_line = 0;
    if (hs_e) begin
      if (m_mode == 0) begin
        m_mode = 1; m_good = 0;
      end else if (pos == 0) begin
        if (m_mode == 1) begin
          m_good++;
          if (m_good == LOCK_LINES) m_mode = 2;
        end
      end else begin
        if (m_mode == 2) m_err++;
        m_mode = 1; m_good = 0;
      end
      m_anchor = m_t;
    end else if (pos == 0 && m_mode != 0) begin
      if (m_mode == 2) m_err++;
      m_mode = 0;
    end
    if (((m_t - m_anchor) % H_TOTAL) == H_TOTAL - 1 && m_line < 2047) m_line++;
    e.de = d;
    if (d) begin
      e.r = {8{p[0]}}; e.g = {8{p[1]}}; e.b = {8{p[2]}};
    end else begin
      e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
      m_hs = p[1]; m_vs = p[2];
    end
    e.hs  = m_hs;
    e.vs  = m_vs;
    e.lk  = (m_mode == 2);
    e.err = (m_err > 65535) ? 16'hFFFF : 16'(m_err);
    m_prev1 = p[1];
    m_prev2 = p[2];
    m_t++;
  endtask

  // One pix_clk: apply lanes, advance the model, check outputs for the
  // sample two cycles old and diff_err for the sample just registered.
  task automatic cycle(input logic [2:0] p, input logic [2:0] n);
    exp_t e_new;
    logic d_exp;
    tmds_d_p = p;
    tmds_d_n = n;
    model_step(p, e_new);
    d_exp = |(p ~^ n);
    @(posedge pix_clk); #1;
    check("de", de, e_prev.de);
    check("hsync", hsync, e_prev.hs);
    check("vsync", vsync, e_prev.vs);
    check("red", red, e_prev.r);
    check("green", green, e_prev.g);
    check("blue", blue, e_prev.b);
    check("locked", locked, e_prev.lk);
    check("line_err_cnt", line_err_cnt, e_prev.err);
    check("diff_err", diff_err, d_exp);
    if (diff_err) diff_seen++;
    e_prev = e_new;
  endtask

  // mode: 0 normal, 1 hsync suppressed, 2 extra hsync pulse at x=10, 3 green toggles
  task automatic send_pixel(input int x, input int y, input int mode);
    logic [2:0] p, n;
    logic hs_b, vs_b;
    hs_b = (x < H_SYNC);
    if (mode == 1) hs_b = 1'b0;
    if (mode == 2 && x == 10) hs_b = 1'b1;
    vs_b = (y < V_SYNC);
    if (x >= HA_LO && x < HA_HI && y >= VA_LO && y < VA_HI) begin
      if (model_de()) begin
        p = 3'($urandom_range(0, 7));
        if (mode == 3) p[1] = (x % 2 == 1);
      end else begin
        p = {2'b00, 1'($urandom_range(0, 1))};
      end
    end else begin
      p = {vs_b, hs_b, 1'b0};
    end
    n = ~p;
    if (diff_pending > 0) begin
      n[1] = p[1];
      diff_pending--;
    end
    cycle(p, n);
  endtask

  task automatic send_line(input int y, input int mode, input int xlast);
    for (int x = 0; x <= xlast; x++) send_pixel(x, y, mode);
  endtask

  task automatic send_frame(input int mode);
    for (int y = 0; y < V_TOTAL; y++) send_line(y, mode, H_TOTAL - 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_de"}, de, 0);
    check({tag, "_hsync"}, hsync, 0);
    check({tag, "_vsync"}, vsync, 0);
    check({tag, "_rgb"}, {red, green, blue}, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_diff_err"}, diff_err, 0);
    check({tag, "_line_err_cnt"}, line_err_cnt, 0);
  endtask

  // Assert reset between clock edges, confirm the outputs clear at once,
  // then release and restart the model from the reset sample.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    repeat (2) @(posedge pix_clk);
    @(negedge pix_clk);
    rst_n = 1'b1;
    m_mode = 0; m_good = 0; m_err = 0; m_line = 0;
    m_prev1 = 0; m_prev2 = 0; m_hs = 0; m_vs = 0;
    m_anchor = m_t;
    model_step(3'b000, e_prev);
  endtask

  // Send one frame, checking that lock appears with the 5th hsync edge (line 4)
  task automatic acquire_frame(input string tag);
    for (int y = 0; y < V_TOTAL; y++) begin
      send_line(y, 0, H_TOTAL - 1);
      if (y == 3) check({tag, "_unlocked_l3"}, locked, 0);
      if (y == 4) check({tag, "_locked_l4"}, locked, 1);
    end
  endtask

  initial begin
    #2;
    do_reset("reset");

    // Clean stream
    acquire_frame("clean");
    send_frame(0);
    check("clean_err", line_err_cnt, 0);

    // Missing hsync on the last line of a frame
    for (int y = 0; y < V_TOTAL - 1; y++) send_line(y, 0, H_TOTAL - 1);
    send_line(V_TOTAL - 1, 1, H_TOTAL - 1);
    check("missing_unlock", locked, 0);
    check("missing_de", de, 0);
    check("missing_err", line_err_cnt, 1);
    acquire_frame("missing_relock");

    // Misplaced hsync at x=10 on a vertical blanking line
    for (int y = 0; y < 6; y++) send_line(y, 0, H_TOTAL - 1);
    send_line(6, 2, H_TOTAL - 1);
    check("misplaced_unlock", locked, 0);
    check("misplaced_err", line_err_cnt, 2);
    send_line(7, 0, H_TOTAL - 1);
    for (int y = 0; y < V_TOTAL; y++) begin
      send_line(y, 0, H_TOTAL - 1);
      if (y == 2) check("misplaced_unlocked_l2", locked, 0);
      if (y == 3) check("misplaced_relock_l3", locked, 1);
    end

    // Green toggling every pixel in the active window
    send_frame(3);
    check("toggle_locked", locked, 1);
    check("toggle_err", line_err_cnt, 2);

    // Three cycles with p == n on lane 1
    send_line(0, 0, H_TOTAL - 1);
    diff_pending = 3;
    for (int y = 1; y < V_TOTAL; y++) send_line(y, 0, H_TOTAL - 1);
    check("diff_cycles", diff_seen, 3);
    check("diff_locked", locked, 1);

    // Reset in the middle of an active line
    for (int y = 0; y < 3; y++) send_line(y, 0, H_TOTAL - 1);
    send_line(3, 0, 12);
    check("pre_reset_de", de, 1);
    #2;
    do_reset("midline");
    acquire_frame("reset_relock");
    send_frame(0);
    check("reset_err", line_err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
